// File: rtl/digit_sprite_renderer.sv
// rtl/digit_sprite_renderer.sv - overlays a 20x20 ROM digit sprite onto the VGA pixel stream
// Three-stage pipeline: window/address, ROM read alignment, pixel select.
module digit_sprite_renderer #(
  parameter logic [9:0] SPRITE_X    = 10'd600,
  parameter logic [9:0] SPRITE_Y    = 10'd20,
  parameter logic [7:0] TRANSPARENT = 8'h00,
  parameter logic [7:0] BG_COLOR    = 8'h00
) (
  input  logic       i_clk2,
  input  logic       i_reset,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_video_on,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic [3:0] i_digit,
  output logic [9:0] o_numberaddr,
  output logic [3:0] o_digit_sel,
  input  logic [7:0] i_numberdata,
  output logic [7:0] o_pixel,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_video_on,
  output logic       o_sprite_hit
);

  // Window ends compared in 11 bits so a window near the right/bottom edge cannot wrap.
  localparam logic [10:0] X_END = {1'b0, SPRITE_X} + 11'd20;
  localparam logic [10:0] Y_END = {1'b0, SPRITE_Y} + 11'd20;

  logic       win_hit;
  logic [9:0] col;
  logic [9:0] row;
  logic [9:0] addr_d;

  logic       hit1_q, hit2_q;
  logic       hs1_q, hs2_q;
  logic       vs1_q, vs2_q;
  logic       von1_q, von2_q;
  logic [9:0] addr_q;

  logic [7:0] pixel_q, pixel_d;
  logic       sprite_hit_q, sprite_hit_d;
  logic       hs3_q, vs3_q, von3_q;

  logic       vs_prev_q;
  logic       edge_arm_q;
  logic       vs_fall;
  logic [3:0] digit_q, digit_d;

  always_comb begin
    win_hit = i_video_on
            && ({1'b0, i_x} >= {1'b0, SPRITE_X}) && ({1'b0, i_x} < X_END)
            && ({1'b0, i_y} >= {1'b0, SPRITE_Y}) && ({1'b0, i_y} < Y_END);
    col     = i_x - SPRITE_X;
    row     = i_y - SPRITE_Y;
    addr_d  = win_hit ? ((row << 4) + (row << 2) + col) : 10'd0;
  end

  always_ff @(posedge i_clk2) begin
    if (i_reset) begin
      hit1_q <= 1'b0;
      addr_q <= 10'd0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      von1_q <= 1'b0;
      hit2_q <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      von2_q <= 1'b0;
    end else begin
      hit1_q <= win_hit;
      addr_q <= addr_d;
      hs1_q  <= i_hsync;
      vs1_q  <= i_vsync;
      von1_q <= i_video_on;
      hit2_q <= hit1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      von2_q <= von1_q;
    end
  end

  // Blanking forces black regardless of the configured background colour.
  always_comb begin
    pixel_d      = 8'h00;
    sprite_hit_d = 1'b0;
    if (von2_q) begin
      if (hit2_q && (i_numberdata != TRANSPARENT)) begin
        pixel_d      = i_numberdata;
        sprite_hit_d = 1'b1;
      end else begin
        pixel_d      = BG_COLOR;
      end
    end
  end

  always_ff @(posedge i_clk2) begin
    if (i_reset) begin
      pixel_q      <= 8'h00;
      sprite_hit_q <= 1'b0;
      hs3_q        <= 1'b1;
      vs3_q        <= 1'b1;
      von3_q       <= 1'b0;
    end else begin
      pixel_q      <= pixel_d;
      sprite_hit_q <= sprite_hit_d;
      hs3_q        <= hs2_q;
      vs3_q        <= vs2_q;
      von3_q       <= von2_q;
    end
  end

  // edge_arm_q masks the first post-reset cycle so a vsync already low is not seen as an edge.
  always_comb begin
    vs_fall = edge_arm_q && vs_prev_q && !i_vsync;
    digit_d = digit_q;
    if (vs_fall) begin
      digit_d = (i_digit <= 4'd9) ? i_digit : 4'd0;
    end
  end

  always_ff @(posedge i_clk2) begin
    if (i_reset) begin
      vs_prev_q  <= 1'b1;
      edge_arm_q <= 1'b0;
      digit_q    <= 4'd0;
    end else begin
      vs_prev_q  <= i_vsync;
      edge_arm_q <= 1'b1;
      digit_q    <= digit_d;
    end
  end

  assign o_numberaddr = addr_q;
  assign o_digit_sel  = digit_q;
  assign o_pixel      = pixel_q;
  assign o_sprite_hit = sprite_hit_q;
  assign o_hsync      = hs3_q;
  assign o_vsync      = vs3_q;
  assign o_video_on   = von3_q;

endmodule

// File: tb/tb_digit_sprite_renderer.sv
// tb/tb_digit_sprite_renderer.sv - directed self-checking bench for digit_sprite_renderer
module tb_digit_sprite_renderer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x, y;
  logic       von, hs, vs;
  logic [3:0] digit;
  logic [9:0] addr;
  logic [3:0] dsel;
  logic [7:0] rom_q;
  logic [7:0] pix;
  logic       ohs, ovs, ovon, shit;

  int checks = 0;
  int errors = 0;
  logic [6:0] hs_pat;

  digit_sprite_renderer dut (
    .i_clk2       (clk),
    .i_reset      (rst),
    .i_x          (x),
    .i_y          (y),
    .i_video_on   (von),
    .i_hsync      (hs),
    .i_vsync      (vs),
    .i_digit      (digit),
    .o_numberaddr (addr),
    .o_digit_sel  (dsel),
    .i_numberdata (rom_q),
    .o_pixel      (pix),
    .o_hsync      (ohs),
    .o_vsync      (ovs),
    .o_video_on   (ovon),
    .o_sprite_hit (shit)
  );

  always #5 clk = ~clk;

  // Registered-read ROM: addr 21 holds E0, otherwise low address byte XOR 5A (addr 90 -> 00).
  always @(posedge clk) begin
    if (addr == 10'd21) rom_q <= 8'hE0;
    else                rom_q <= addr[7:0] ^ 8'h5A;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] nx, input logic [9:0] ny, input logic nvon);
    x = nx; y = ny; von = nvon;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; x = 10'd0; y = 10'd0; von = 1'b0; hs = 1'b1; vs = 1'b1; digit = 4'd0;
    step(); step();
    check("rst_addr", 16'(addr), 16'd0);
    check("rst_dsel", 16'(dsel), 16'd0);
    check("rst_pix",  16'(pix),  16'h00);
    check("rst_hit",  16'(shit), 16'd0);
    check("rst_von",  16'(ovon), 16'd0);
    check("rst_hs",   16'(ohs),  16'd1);
    check("rst_vs",   16'(ovs),  16'd1);

    rst = 1'b0;
    drive(10'd600, 10'd20, 1'b1); step();
    check("addr_first", 16'(addr), 16'd0);
    drive(10'd619, 10'd39, 1'b1); step();
    check("addr_last", 16'(addr), 16'd399);
    drive(10'd620, 10'd20, 1'b1); step();
    check("addr_xout", 16'(addr), 16'd0);
    check("pix_600_20", 16'(pix), 16'h5A);
    check("hit_600_20", 16'(shit), 16'd1);
    drive(10'd601, 10'd21, 1'b1); step();
    check("addr_21", 16'(addr), 16'd21);
    check("pix_619_39", 16'(pix), 16'hD5);
    drive(10'd610, 10'd24, 1'b1); step();
    check("addr_90", 16'(addr), 16'd90);
    check("pix_620_out", 16'(pix), 16'h00);
    check("hit_620_out", 16'(shit), 16'd0);
    drive(10'd605, 10'd40, 1'b1); step();
    check("addr_yout", 16'(addr), 16'd0);
    check("pix_601_21", 16'(pix), 16'hE0);
    check("hit_601_21", 16'(shit), 16'd1);
    drive(10'd605, 10'd25, 1'b0); step();
    check("pix_transp", 16'(pix), 16'h00);
    check("hit_transp", 16'(shit), 16'd0);
    check("von_transp", 16'(ovon), 16'd1);
    drive(10'd0, 10'd0, 1'b0); step();
    check("pix_yout", 16'(pix), 16'h00);
    check("hit_yout", 16'(shit), 16'd0);
    step();
    check("pix_blank", 16'(pix), 16'h00);
    check("hit_blank", 16'(shit), 16'd0);
    check("von_blank", 16'(ovon), 16'd0);

    hs_pat = 7'b1111001;  // bit k driven at step k: 1,0,0,1,1,1,1
    for (int k = 0; k < 7; k++) begin
      hs = hs_pat[k];
      step();
      if (k >= 2) check($sformatf("hs_delay_%0d", k), 16'(ohs), 16'(hs_pat[k-2]));
    end
    hs = 1'b1;

    digit = 4'd4; vs = 1'b1; step();
    vs = 1'b0; step();
    check("dsel_4", 16'(dsel), 16'd4);
    digit = 4'd7; step(); step();
    check("dsel_hold_low", 16'(dsel), 16'd4);
    vs = 1'b1; step(); step();
    check("dsel_hold_high", 16'(dsel), 16'd4);
    digit = 4'd12; vs = 1'b0; step();
    check("dsel_12", 16'(dsel), 16'd0);
    digit = 4'd9; vs = 1'b1; step();
    vs = 1'b0; step();
    check("dsel_9", 16'(dsel), 16'd9);

    drive(10'd601, 10'd21, 1'b1); hs = 1'b0; digit = 4'd5;
    step(); step(); step();
    check("pre_rst_pix", 16'(pix), 16'hE0);
    rst = 1'b1; step();
    check("mid_rst_addr", 16'(addr), 16'd0);
    check("mid_rst_dsel", 16'(dsel), 16'd0);
    check("mid_rst_pix",  16'(pix),  16'h00);
    check("mid_rst_hit",  16'(shit), 16'd0);
    check("mid_rst_von",  16'(ovon), 16'd0);
    check("mid_rst_hs",   16'(ohs),  16'd1);
    check("mid_rst_vs",   16'(ovs),  16'd1);
    rst = 1'b0; step();
    check("post_rst_dsel", 16'(dsel), 16'd0);
    check("post_rst_addr", 16'(addr), 16'd21);
    step();
    check("post_rst_pix2", 16'(pix), 16'h00);
    check("post_rst_von2", 16'(ovon), 16'd0);
    step();
    check("post_rst_pix3", 16'(pix), 16'hE0);
    check("post_rst_hit3", 16'(shit), 16'd1);
    check("post_rst_hs3",  16'(ohs),  16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
